// File: rtl/sram_pkg.sv
// ============================================================================
// Module  : sram_pkg
// Brief   : Shared types and defaults for the SRAM read controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sram_pkg;

  localparam int ADDR_W_DEF    = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int SENSE_CYC_DEF = 2;
  localparam int CNT_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

endpackage : sram_pkg

`default_nettype wire

// File: rtl/sram_wl_decoder.sv
// ============================================================================
// Module  : sram_wl_decoder
// Brief   : Row address to one-hot word-line decoder, gated by enable.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_wl_decoder #(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [(1<<ADDR_W)-1:0] wl
);

  localparam int N_ROWS = 1 << ADDR_W;

  for (genvar i = 0; i < N_ROWS; i++) begin : g_row
    assign wl[i] = en && (addr == ADDR_W'(i));
  end

endmodule : sram_wl_decoder

`default_nettype wire

// File: rtl/sram_read_ctrl.sv
// ============================================================================
// Module  : sram_read_ctrl
// Brief   : Single-port SRAM read sequencer (precharge/access/capture/resp).
//           Optional parity check enabled by macro SRAM_READ_PARITY_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_read_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SENSE_CYC = SENSE_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [(1<<ADDR_W)-1:0] wl,
  output logic                   precharge,
  output logic                   sense_en,
  input  logic [DATA_W-1:0]      bl_data
`ifdef SRAM_READ_PARITY_EN
  ,
  input  logic                   bl_par,
  output logic                   rsp_err
`endif
);

  localparam logic [CNT_W-1:0] SENSE_LOAD = CNT_W'(SENSE_CYC);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               wl_en;

  // State register plus the datapath flops that travel with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = ST_PRECHARGE;
        end
      end
      ST_PRECHARGE: begin
        cnt_d   = SENSE_LOAD;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Counter is loaded with SENSE_CYC, so ACCESS spans SENSE_CYC cycles
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        rsp_data_d = bl_data;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    precharge = 1'b0;
    sense_en  = 1'b0;
    rsp_valid = 1'b0;
    wl_en     = 1'b0;
    case (state_q)
      ST_IDLE:      req_ready = 1'b1;
      ST_PRECHARGE: precharge = 1'b1;
      ST_ACCESS:    wl_en     = 1'b1;
      ST_CAPTURE: begin
        wl_en    = 1'b1;
        sense_en = 1'b1;
      end
      ST_RESP:      rsp_valid = 1'b1;
      default:      req_ready = 1'b0;
    endcase
  end

  assign rsp_data = rsp_data_q;

  sram_wl_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wl_decoder (
    .addr (addr_q),
    .en   (wl_en),
    .wl   (wl)
  );

`ifdef SRAM_READ_PARITY_EN
  logic rsp_err_q, rsp_err_d;

  always_comb begin
    rsp_err_d = rsp_err_q;
    if (state_q == ST_CAPTURE) rsp_err_d = (^bl_data) ^ bl_par;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rsp_err_q <= 1'b0;
    else        rsp_err_q <= rsp_err_d;
  end

  assign rsp_err = rsp_err_q;
`endif

endmodule : sram_read_ctrl

`default_nettype wire

// File: tb/tb_sram_read_ctrl.sv
// ============================================================================
// Module  : tb_sram_read_ctrl
// Brief   : Directed bench with a cycle-timeline reference model for
//           sram_read_ctrl (parity checks under SRAM_READ_PARITY_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_read_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SC = 2;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [NR-1:0] wl;
  logic          precharge;
  logic          sense_en;
  logic [DW-1:0] bl_data;
`ifdef SRAM_READ_PARITY_EN
  logic          bl_par;
  logic          rsp_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_read_ctrl #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .SENSE_CYC (SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .wl        (wl),
    .precharge (precharge),
    .sense_en  (sense_en),
    .bl_data   (bl_data)
`ifdef SRAM_READ_PARITY_EN
    ,
    .bl_par    (bl_par),
    .rsp_err   (rsp_err)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a request occupies a timeline of cycles k=0..SC+1 after
  // acceptance (k=0 precharge, k>=1 word line, k=SC+1 sensing), then waits
  // in the response phase until the consumer takes it.
  bit            m_on   = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_resp = 1'b0;
  int            m_k    = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_err  = 1'b0;

  always @(posedge clk) begin
    m_on = 1'b1;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_resp = 1'b0;
      m_data = '0;
      m_err  = 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_addr = req_addr;
      end
    end else if (m_resp) begin
      if (rsp_ready) begin
        m_busy = 1'b0;
        m_resp = 1'b0;
      end
    end else if (m_k == SC + 1) begin
      m_resp = 1'b1;
      m_data = bl_data;
`ifdef SRAM_READ_PARITY_EN
      m_err  = (^bl_data) ^ bl_par;
`endif
    end else begin
      m_k++;
    end
  end

  always @(negedge clk) begin : p_compare
    logic [NR-1:0] ewl;
    logic          in_seq;
    if (m_on) begin
      in_seq = m_busy && !m_resp;
      ewl    = (in_seq && m_k >= 1) ? (NR'(1) << m_addr) : '0;
      chk("req_ready", req_ready, !m_busy);
      chk("precharge", precharge, in_seq && m_k == 0);
      chk("sense_en", sense_en, in_seq && m_k == SC + 1);
      chk("rsp_valid", rsp_valid, m_resp);
      chk("wl", wl, ewl);
      chk("rsp_data", rsp_data, m_data);
`ifdef SRAM_READ_PARITY_EN
      chk("rsp_err", rsp_err, m_err);
`endif
      chk("wl_onehot0", $onehot0(wl), 1'b1);
      chk("precharge_wl_overlap", precharge && (wl != '0), 1'b0);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Called at a negedge while idle; returns at the negedge of cycle k=0.
  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy);
    req_addr  = a;
    bl_data   = d;
    rsp_ready = rdy;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 30) begin
      cyc();
      n++;
    end
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_stim
    int n, pc, wc, nv, bad;
    logic [AW-1:0] t_addr [4];
    logic [DW-1:0] t_data [4];
    t_addr = '{4'h1, 4'h7, 4'hC, 4'hE};
    t_data = '{32'h0000_0001, 32'h8000_0000, 32'hCAFE_F00D, 32'h1234_5678};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; bl_data = '0;
`ifdef SRAM_READ_PARITY_EN
    bl_par = 1'b0;
`endif
    repeat (2) cyc();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_wl", wl, '0);
    chk("rst_precharge", precharge, 1'b0);
    chk("rst_sense_en", sense_en, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Basic read
    issue(4'h5, 32'hDEAD_BEEF, 1'b1);
    n = 0; pc = 0; wc = 0;
    while (!rsp_valid && n < 30) begin
      if (precharge) pc++;
      if (wl == 16'h0020) wc++;
      cyc();
      n++;
    end
    chk("s1_precharge_cycles", pc, 1);
    chk("s1_wl_cycles", wc, 3);
    chk("s1_latency", n, 4);
    chk("s1_data", rsp_data, 32'hDEAD_BEEF);
    cyc();
    chk("s1_valid_one_cycle", rsp_valid, 1'b0);
    chk("s1_ready_after", req_ready, 1'b1);

    // Backpressure
    issue(4'h3, 32'hDEAD_BEEF, 1'b0);
    wait_rsp(n);
    chk("s2_latency", n, 4);
    bl_data = '0;
    repeat (5) begin
      cyc();
      chk("s2_data_hold", rsp_data, 32'hDEAD_BEEF);
      chk("s2_ready_low", req_ready, 1'b0);
      chk("s2_valid_hold", rsp_valid, 1'b1);
    end
    rsp_ready = 1'b1;
    cyc();
    chk("s2_ready_next", req_ready, 1'b1);

    // Reset mid-ACCESS
    issue(4'hF, 32'h1234_5678, 1'b1);
    cyc();
    chk("s3_wl_access", wl, 16'h8000);
    rst_n = 1'b0;
    cyc();
    chk("s3_wl", wl, '0);
    chk("s3_rsp_valid", rsp_valid, 1'b0);
    chk("s3_req_ready", req_ready, 1'b1);
    chk("s3_rsp_data", rsp_data, '0);
    rst_n = 1'b1;
    nv = 0;
    repeat (10) begin
      cyc();
      if (rsp_valid) nv++;
    end
    chk("s3_no_response", nv, 0);

    // Address stability and ignored request during RESP
    issue(4'h0, 32'hA5A5_5A5A, 1'b0);
    req_addr = 4'hA;
    n = 0; wc = 0; bad = 0;
    while (!rsp_valid && n < 30) begin
      if (wl == 16'h0001) wc++;
      else if (wl != '0) bad++;
      cyc();
      n++;
    end
    chk("s4_wl_stable", bad, 0);
    chk("s4_wl_cycles", wc, 3);
    chk("s4_data", rsp_data, 32'hA5A5_5A5A);
    req_valid = 1'b1;
    req_addr  = 4'h7;
    cyc();
    chk("s4_pulse_still_resp", rsp_valid, 1'b1);
    chk("s4_pulse_no_precharge", precharge, 1'b0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    cyc();
    chk("s4_ready_after", req_ready, 1'b1);
    cyc();
    chk("s4_not_accepted", precharge, 1'b0);

    // Back-to-back reads over several rows
    for (int i = 0; i < 4; i++) begin
      issue(t_addr[i], t_data[i], 1'b1);
      wait_rsp(n);
      chk("s5_latency", n, 4);
      chk("s5_data", rsp_data, t_data[i]);
      cyc();
    end
    chk("s5_data_retained", rsp_data, 32'h1234_5678);

`ifdef SRAM_READ_PARITY_EN
    bl_par = 1'b0;
    issue(4'h2, 32'h0000_0001, 1'b1);
    wait_rsp(n);
    chk("par_err_set", rsp_err, 1'b1);
    cyc();
    bl_par = 1'b1;
    issue(4'h2, 32'h0000_0001, 1'b1);
    wait_rsp(n);
    chk("par_err_clear", rsp_err, 1'b0);
    cyc();
`endif

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sram_read_ctrl

`default_nettype wire
